vadd_minmax_sat: RTL and testbench



---
 rtl/vadd_minmax_sat.sv | 272 +++++++++++++++++++++++++++
 tb/tb_vadd_minmax_sat.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vadd_minmax_sat.sv
// vadd_minmax_sat: lane-parallel add/sub/min/max with saturating ops and packed compare masks.
// Two-stage pipeline: S1 registers lane results, S2 is the output / mask packing register.
module vadd_minmax_sat #(
    parameter int unsigned DATA_WIDTH    = 64,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter bit          ENABLE_64_BIT = 1'b0,
    parameter bit          SAT_ENABLE    = 1'b1,
    parameter bit          MASK_ENABLE   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_WIDTH-1:0]   in_vec0,
    input  logic [DATA_WIDTH-1:0]   in_vec1,
    input  logic [1:0]              in_sew,
    input  logic [3:0]              in_op,
    input  logic [DATA_WIDTH/8-1:0] in_be,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic                    in_first,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_vec,
    output logic [DATA_WIDTH/8-1:0] out_be,
    output logic [ADDR_WIDTH-1:0]   out_addr,
    output logic                    out_mask,
    output logic                    out_sat,
    input  logic                    sat_clr,
    output logic                    sat_flag
);

    localparam int unsigned DW  = DATA_WIDTH;
    localparam int unsigned BW  = DATA_WIDTH / 8;
    localparam int unsigned BW1 = BW + 1;
    localparam int unsigned PW  = $clog2(DATA_WIDTH + 1);

    // Per-SEW lane results; index is in_sew.
    logic [3:0][DW-1:0] w_res_s;
    logic [3:0][BW-1:0] w_sat_s;
    logic [3:0][BW-1:0] w_cmp_s;

    for (genvar g = 0; g < 4; g++) begin : g_sew
        localparam int unsigned EW      = 8 << g;
        localparam int unsigned NE      = (EW <= DW) ? DW / EW : 0;
        localparam bit          LANE_ON = (g < 3) || (ENABLE_64_BIT && (DW >= 64));

        if (LANE_ON && (NE > 0)) begin : g_on
            for (genvar e = 0; e < NE; e++) begin : g_el
                localparam logic [EW-1:0] SMAX = {1'b0, {(EW-1){1'b1}}};
                localparam logic [EW-1:0] SMIN = {1'b1, {(EW-1){1'b0}}};

                logic [EW-1:0] w_a;
                logic [EW-1:0] w_b;
                logic [EW:0]   w_uadd;
                logic [EW:0]   w_usub;
                logic [EW-1:0] w_clamp;
                logic          w_ult;
                logic          w_slt;
                logic          w_eq;
                logic          w_sovf_add;
                logic          w_sovf_sub;
                logic          w_act;
                logic [EW-1:0] w_res;
                logic          w_sat;
                logic          w_cmp;

                assign w_a        = in_vec0[e*EW +: EW];
                assign w_b        = in_vec1[e*EW +: EW];
                assign w_act      = in_be[e*EW/8];
                assign w_uadd     = {1'b0, w_a} + {1'b0, w_b};
                assign w_usub     = {1'b0, w_a} - {1'b0, w_b};
                assign w_ult      = w_usub[EW];
                assign w_eq       = (w_a == w_b);
                // Differing signs decide signed order directly; otherwise unsigned order holds.
                assign w_slt      = (w_a[EW-1] != w_b[EW-1]) ? w_a[EW-1] : w_ult;
                assign w_sovf_add = (w_a[EW-1] == w_b[EW-1]) && (w_uadd[EW-1] != w_a[EW-1]);
                assign w_sovf_sub = (w_a[EW-1] != w_b[EW-1]) && (w_usub[EW-1] != w_a[EW-1]);
                // Signed overflow always goes toward the sign of vec0.
                assign w_clamp    = w_a[EW-1] ? SMIN : SMAX;

                // Lane operation select with optional saturation.
                always_comb begin
                    w_res = '0;
                    w_sat = 1'b0;
                    w_cmp = 1'b0;
                    case (in_op)
                        4'd0: w_res = w_uadd[EW-1:0];
                        4'd1: w_res = w_usub[EW-1:0];
                        4'd2: w_res = w_ult ? w_a : w_b;
                        4'd3: w_res = w_slt ? w_a : w_b;
                        4'd4: w_res = w_ult ? w_b : w_a;
                        4'd5: w_res = w_slt ? w_b : w_a;
                        4'd6: begin
                            w_res = w_uadd[EW-1:0];
                            if (SAT_ENABLE && w_uadd[EW]) begin
                                w_res = '1;
                                w_sat = 1'b1;
                            end
                        end
                        4'd7: begin
                            w_res = w_uadd[EW-1:0];
                            if (SAT_ENABLE && w_sovf_add) begin
                                w_res = w_clamp;
                                w_sat = 1'b1;
                            end
                        end
                        4'd8: begin
                            w_res = w_usub[EW-1:0];
                            if (SAT_ENABLE && w_ult) begin
                                w_res = '0;
                                w_sat = 1'b1;
                            end
                        end
                        4'd9: begin
                            w_res = w_usub[EW-1:0];
                            if (SAT_ENABLE && w_sovf_sub) begin
                                w_res = w_clamp;
                                w_sat = 1'b1;
                            end
                        end
                        4'd10:   w_cmp = w_eq;
                        4'd11:   w_cmp = ~w_eq;
                        4'd12:   w_cmp = w_ult;
                        4'd13:   w_cmp = w_slt;
                        4'd14:   w_cmp = w_ult | w_eq;
                        default: w_cmp = w_slt | w_eq;
                    endcase
                end

                assign w_res_s[g][e*EW +: EW] = w_act ? w_res : '0;
                assign w_sat_s[g][e]          = w_act & w_sat;
                assign w_cmp_s[g][e]          = w_act & w_cmp;
            end

            if (NE < BW) begin : g_pad
                assign w_sat_s[g][BW-1:NE] = '0;
                assign w_cmp_s[g][BW-1:NE] = '0;
            end
        end else begin : g_off
            assign w_res_s[g] = '0;
            assign w_sat_s[g] = '0;
            assign w_cmp_s[g] = '0;
        end
    end

    logic          w_adv;
    logic [DW-1:0] w_res;
    logic          w_sat;
    logic [BW-1:0] w_cmp;
    logic          w_is_cmp;
    logic [PW-1:0] w_n;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;
    assign w_res    = w_res_s[in_sew];
    assign w_sat    = |w_sat_s[in_sew];
    assign w_cmp    = w_cmp_s[in_sew];
    assign w_is_cmp = (in_op >= 4'd10);
    assign w_n      = PW'(BW >> in_sew);

    logic                  r1_valid;
    logic [DW-1:0]         r1_res;
    logic                  r1_sat;
    logic [BW-1:0]         r1_cmp;
    logic [BW-1:0]         r1_be;
    logic [ADDR_WIDTH-1:0] r1_addr;
    logic                  r1_first;
    logic                  r1_last;
    logic                  r1_is_cmp;
    logic [PW-1:0]         r1_n;

    // S1: capture lane results of the accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r1_res    <= '0;
            r1_sat    <= 1'b0;
            r1_cmp    <= '0;
            r1_be     <= '0;
            r1_addr   <= '0;
            r1_first  <= 1'b0;
            r1_last   <= 1'b0;
            r1_is_cmp <= 1'b0;
            r1_n      <= '0;
        end else if (w_adv) begin
            r1_valid  <= in_valid;
            r1_res    <= w_res;
            r1_sat    <= w_sat;
            r1_cmp    <= w_cmp;
            r1_be     <= in_be;
            r1_addr   <= in_addr;
            r1_first  <= in_first;
            r1_last   <= in_last;
            r1_is_cmp <= w_is_cmp;
            r1_n      <= w_n;
        end
    end

    logic [PW-1:0]         r_ptr;
    logic [DW-1:0]         r_pack;
    logic [ADDR_WIDTH-1:0] r_waddr;

    logic [PW-1:0]         w_base;
    logic [PW-1:0]         w_ptr_nxt;
    logic [PW-1:0]         w_bytes;
    logic [DW-1:0]         w_merged;
    logic [BW:0]           w_fill;
    logic                  w_emit;
    logic [ADDR_WIDTH-1:0] w_word_addr;

    // Mask packing: merge this beat's compare bits at the current pointer.
    always_comb begin
        w_base      = r1_first ? '0 : r_ptr;
        w_merged    = (r1_first ? '0 : r_pack) | (DW'(r1_cmp) << w_base);
        w_ptr_nxt   = w_base + r1_n;
        w_emit      = (w_ptr_nxt == PW'(DW)) || r1_last;
        w_bytes     = (w_ptr_nxt + PW'(7)) >> 3;
        w_fill      = (BW1'(1) << w_bytes) - BW1'(1);
        w_word_addr = (w_base == '0) ? r1_addr : r_waddr;
    end

    // S2: output register, pack state and sticky saturation flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_vec   <= '0;
            out_be    <= '0;
            out_addr  <= '0;
            out_mask  <= 1'b0;
            out_sat   <= 1'b0;
            sat_flag  <= 1'b0;
            r_ptr     <= '0;
            r_pack    <= '0;
            r_waddr   <= '0;
        end else begin
            if (out_valid && out_ready && out_sat) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end

            if (w_adv) begin
                out_valid <= 1'b0;
                if (r1_valid && !r1_is_cmp) begin
                    out_valid <= 1'b1;
                    out_vec   <= r1_res;
                    out_be    <= r1_be;
                    out_addr  <= r1_addr;
                    out_mask  <= 1'b0;
                    out_sat   <= r1_sat;
                end else if (r1_valid && MASK_ENABLE) begin
                    if (w_emit) begin
                        out_valid <= 1'b1;
                        out_vec   <= w_merged;
                        out_be    <= w_fill[BW-1:0];
                        out_addr  <= w_word_addr;
                        out_mask  <= 1'b1;
                        out_sat   <= 1'b0;
                        r_ptr     <= '0;
                        r_pack    <= '0;
                    end else begin
                        r_ptr     <= w_ptr_nxt;
                        r_pack    <= w_merged;
                        r_waddr   <= w_word_addr;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vadd_minmax_sat.sv
// Self-checking bench for vadd_minmax_sat: directed test-plan steps then randomized traffic
// against an arithmetic reference model and an expected-output queue.
module tb_vadd_minmax_sat;

    localparam int DW = 64;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_vec0;
    logic [DW-1:0] in_vec1;
    logic [1:0]    in_sew;
    logic [3:0]    in_op;
    logic [7:0]    in_be;
    logic [AW-1:0] in_addr;
    logic          in_first;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_vec;
    logic [7:0]    out_be;
    logic [AW-1:0] out_addr;
    logic          out_mask;
    logic          out_sat;
    logic          sat_clr;
    logic          sat_flag;

    vadd_minmax_sat #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ENABLE_64_BIT(1'b0),
        .SAT_ENABLE(1'b1), .MASK_ENABLE(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_vec0(in_vec0), .in_vec1(in_vec1), .in_sew(in_sew), .in_op(in_op),
        .in_be(in_be), .in_addr(in_addr), .in_first(in_first), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_vec(out_vec), .out_be(out_be),
        .out_addr(out_addr), .out_mask(out_mask), .out_sat(out_sat),
        .sat_clr(sat_clr), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] vec;
        logic [7:0]  be;
        logic [31:0] addr;
        logic        mask;
        logic        sat;
        int          t_acc;
    } exp_t;

    exp_t        q[$];
    bit          m_bits[$];
    logic [31:0] m_waddr;
    logic        m_flag = 1'b0;
    int          cycnt  = 0;
    bit          acc    = 1'b0;
    bit          lat_chk = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: element-wise integer arithmetic with explicit clamping.
    function automatic void ref_lanes(input logic [63:0] v0, input logic [63:0] v1,
                                      input logic [1:0] sew, input logic [3:0] op,
                                      input logic [7:0] be, output logic [63:0] res,
                                      output logic sat, output logic [7:0] bits, output int n);
        int ew;
        longint ua, ub, sa, sb, r, umax, half, smax, smin;
        bit c, s;
        ew = 8 << sew;
        n = 64 / ew;
        res = '0; sat = 1'b0; bits = '0;
        if (ew == 64) return;
        umax = (longint'(1) << ew) - 1;
        half = longint'(1) << (ew - 1);
        smax = half - 1;
        smin = -half;
        for (int e = 0; e < n; e++) begin
            ua = longint'(v0 >> (e * ew)) & umax;
            ub = longint'(v1 >> (e * ew)) & umax;
            sa = (ua >= half) ? ua - (umax + 1) : ua;
            sb = (ub >= half) ? ub - (umax + 1) : ub;
            r = 0; s = 0; c = 0;
            case (op)
                4'd0: r = ua + ub;
                4'd1: r = ua - ub;
                4'd2: r = (ua < ub) ? ua : ub;
                4'd3: r = (sa < sb) ? sa : sb;
                4'd4: r = (ua > ub) ? ua : ub;
                4'd5: r = (sa > sb) ? sa : sb;
                4'd6: begin r = ua + ub; if (r > umax) begin r = umax; s = 1; end end
                4'd7: begin
                    r = sa + sb;
                    if (r > smax) begin r = smax; s = 1; end
                    else if (r < smin) begin r = smin; s = 1; end
                end
                4'd8: begin r = ua - ub; if (r < 0) begin r = 0; s = 1; end end
                4'd9: begin
                    r = sa - sb;
                    if (r > smax) begin r = smax; s = 1; end
                    else if (r < smin) begin r = smin; s = 1; end
                end
                4'd10: c = (ua == ub);
                4'd11: c = (ua != ub);
                4'd12: c = (ua < ub);
                4'd13: c = (sa < sb);
                4'd14: c = (ua <= ub);
                default: c = (sa <= sb);
            endcase
            if (be[e * ew / 8]) begin
                res |= 64'(r & umax) << (e * ew);
                sat |= s;
                bits[e] = c;
            end
        end
    endfunction

    // One clock: check/record handshakes at negedge, advance, check the sticky flag.
    task automatic cyc();
        exp_t        e;
        logic [63:0] r;
        logic        s;
        logic [7:0]  bits;
        int          n;
        logic [63:0] w;
        logic [7:0]  wbe;
        bit          popped_sat;
        acc = 1'b0;
        popped_sat = 1'b0;
        @(negedge clk);
        cycnt++;
        if (rst) begin
            q.delete();
            m_bits.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 64'(out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("out_vec",  out_vec, e.vec);
                    chk("out_be",   64'(out_be), 64'(e.be));
                    chk("out_addr", 64'(out_addr), 64'(e.addr));
                    chk("out_mask", 64'(out_mask), 64'(e.mask));
                    chk("out_sat",  64'(out_sat), 64'(e.sat));
                    if (lat_chk) chk("latency", 64'(cycnt - e.t_acc), 64'd2);
                    popped_sat = e.sat;
                end
            end
            if (in_valid && in_ready) begin
                acc = 1'b1;
                ref_lanes(in_vec0, in_vec1, in_sew, in_op, in_be, r, s, bits, n);
                if (in_op < 4'd10) begin
                    q.push_back('{r, in_be, in_addr, 1'b0, s, cycnt});
                end else begin
                    if (in_first) m_bits.delete();
                    if (m_bits.size() == 0) m_waddr = in_addr;
                    for (int i = 0; i < n; i++) m_bits.push_back(bits[i]);
                    if (m_bits.size() == 64 || in_last) begin
                        w = '0;
                        wbe = '0;
                        for (int i = 0; i < m_bits.size(); i++) w[i] = m_bits[i];
                        for (int k = 0; k < (m_bits.size() + 7) / 8; k++) wbe[k] = 1'b1;
                        q.push_back('{w, wbe, m_waddr, 1'b1, 1'b0, cycnt});
                        m_bits.delete();
                    end
                end
            end
        end
        if (rst) m_flag = 1'b0;
        else if (popped_sat) m_flag = 1'b1;
        else if (sat_clr) m_flag = 1'b0;
        @(posedge clk);
        #1;
        chk("sat_flag", 64'(sat_flag), 64'(m_flag));
    endtask

    // Drive one beat and hold it until accepted (bounded).
    task automatic send(input logic [3:0] op, input logic [1:0] sew, input logic [63:0] v0,
                        input logic [63:0] v1, input logic [7:0] be, input logic [31:0] addr,
                        input logic first, input logic last);
        int k;
        in_valid = 1'b1; in_op = op; in_sew = sew; in_vec0 = v0; in_vec1 = v1;
        in_be = be; in_addr = addr; in_first = first; in_last = last;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!acc && k < 100);
        chk("accepted", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    // Single arithmetic beat, then check the visible result two cycles after acceptance.
    task automatic one(input string tag, input logic [3:0] op, input logic [1:0] sew,
                       input logic [63:0] v0, input logic [63:0] v1,
                       input logic [63:0] exp_vec, input logic exp_sat);
        send(op, sew, v0, v1, 8'hFF, 32'h40, 1'b1, 1'b1);
        cyc();
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_vec"}, out_vec, exp_vec);
        chk({tag, "_sat"}, 64'(out_sat), 64'(exp_sat));
    endtask

    localparam logic [63:0] A5_V0 = 64'h8000_8000_0080_0080;

    initial begin
        logic [63:0] held;
        logic [63:0] v0, v1;
        logic [3:0]  op;
        logic [1:0]  sew;
        int          sent, ci, len, k;

        rst = 1'b1; in_valid = 1'b0; in_vec0 = '0; in_vec1 = '0; in_sew = '0; in_op = '0;
        in_be = '0; in_addr = '0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        sat_clr = 1'b0;

        // Reset state.
        repeat (3) cyc();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_vec",   out_vec, 64'd0);
        chk("rst_out_be",    64'(out_be), 64'd0);
        chk("rst_out_addr",  64'(out_addr), 64'd0);
        chk("rst_out_mask",  64'(out_mask), 64'd0);
        chk("rst_out_sat",   64'(out_sat), 64'd0);
        rst = 1'b0;
        cyc();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Signed saturation and sticky flag.
        out_ready = 1'b1;
        lat_chk = 1'b1;
        one("sadd8", 4'd7, 2'd0, 64'h807F, 64'hFF01, 64'h807F, 1'b1);
        cyc();
        chk("flag_set", 64'(sat_flag), 64'd1);
        repeat (2) cyc();
        chk("flag_hold", 64'(sat_flag), 64'd1);
        sat_clr = 1'b1; cyc(); sat_clr = 1'b0;
        chk("flag_clr", 64'(sat_flag), 64'd0);
        one("sadd8b", 4'd7, 2'd0, 64'h807F, 64'hFF01, 64'h807F, 1'b1);
        sat_clr = 1'b1; cyc(); sat_clr = 1'b0;
        chk("flag_set_wins", 64'(sat_flag), 64'd1);
        sat_clr = 1'b1; cyc(); sat_clr = 1'b0;

        // Unsigned saturation, plain add wrap, SEW=16 min/max.
        one("saddu", 4'd6, 2'd0, 64'hFF, 64'h02, 64'hFF, 1'b1);
        one("ssubu", 4'd8, 2'd0, 64'h01, 64'h02, 64'h00, 1'b1);
        one("add",   4'd0, 2'd0, 64'hFF, 64'h02, 64'h01, 1'b0);
        one("min16",  4'd3, 2'd1, 64'h8000, 64'h0001, 64'h8000, 1'b0);
        one("minu16", 4'd2, 2'd1, 64'h8000, 64'h0001, 64'h0001, 1'b0);
        one("max16",  4'd5, 2'd1, 64'h8000, 64'h0001, 64'h0001, 1'b0);
        repeat (2) cyc();

        // Three mslt beats ending on in_last: partial mask word.
        send(4'd13, 2'd0, A5_V0, 64'd0, 8'hFF, 32'h100, 1'b1, 1'b0);
        send(4'd13, 2'd0, A5_V0, 64'd0, 8'hFF, 32'h108, 1'b0, 1'b0);
        send(4'd13, 2'd0, A5_V0, 64'd0, 8'hFF, 32'h110, 1'b0, 1'b1);
        chk("mask3_early", 64'(out_valid), 64'd0);
        cyc();
        chk("mask3_valid", 64'(out_valid), 64'd1);
        chk("mask3_vec",   out_vec, 64'h0000_0000_00A5_A5A5);
        chk("mask3_be",    64'(out_be), 64'h07);
        chk("mask3_addr",  64'(out_addr), 64'h100);
        chk("mask3_mask",  64'(out_mask), 64'd1);
        cyc();

        // Eight beats fill a full word.
        for (int i = 0; i < 8; i++)
            send(4'd13, 2'd0, A5_V0, 64'd0, 8'hFF, 32'h200 + 32'(i * 8), (i == 0), 1'b0);
        cyc();
        chk("mask8_vec",  out_vec, 64'hA5A5_A5A5_A5A5_A5A5);
        chk("mask8_be",   64'(out_be), 64'hFF);
        chk("mask8_addr", 64'(out_addr), 64'h200);
        repeat (2) cyc();

        // Backpressure: out_ready low for three cycles mid-stream.
        lat_chk = 1'b0;
        sent = 0; ci = 0; held = '0;
        while (sent < 8 && ci < 60) begin
            in_valid = 1'b1; in_op = 4'(sent % 2); in_sew = 2'(sent % 3);
            in_vec0 = {$urandom, $urandom}; in_vec1 = {$urandom, $urandom};
            in_be = 8'hFF; in_addr = 32'h300 + 32'(sent); in_first = 1'b1; in_last = 1'b1;
            out_ready = !(ci >= 3 && ci <= 5);
            if (ci == 3) held = out_vec;
            #1;
            if (!out_ready) begin
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_hold", out_vec, held);
            end
            cyc();
            if (acc) sent++;
            ci++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stall_sent", 64'(sent), 64'd8);
        repeat (4) cyc();

        // Reset in the middle of a compare instruction.
        v0 = {$urandom, $urandom};
        send(4'd10, 2'd0, v0, v0, 8'hFF, 32'h400, 1'b1, 1'b0);
        send(4'd10, 2'd0, v0, v0, 8'hFF, 32'h408, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_vec",   out_vec, 64'd0);
        chk("mrst_be",    64'(out_be), 64'd0);
        chk("mrst_mask",  64'(out_mask), 64'd0);
        cyc();
        rst = 1'b0;
        cyc();
        send(4'd11, 2'd0, v0, v0, 8'hFF, 32'h500, 1'b1, 1'b0);
        send(4'd11, 2'd0, v0, v0, 8'hFF, 32'h508, 1'b0, 1'b1);
        cyc();
        chk("post_rst_vec", out_vec, 64'd0);
        chk("post_rst_be",  64'(out_be), 64'h03);
        chk("post_rst_addr", 64'(out_addr), 64'h500);
        repeat (2) cyc();

        // Randomized instructions with random backpressure and flag clears.
        for (int ins = 0; ins < 60; ins++) begin
            op  = 4'($urandom_range(15));
            sew = ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2));
            len = $urandom_range(6, 1);
            for (int b = 0; b < len; b++) begin
                v0 = {$urandom, $urandom};
                v1 = ($urandom_range(3) == 0) ? (v0 ^ (64'h1 << $urandom_range(63))) :
                                                {$urandom, $urandom};
                if ($urandom_range(3) == 0) begin
                    in_valid = 1'b0;
                    out_ready = ($urandom_range(3) != 0);
                    sat_clr = ($urandom_range(9) == 0);
                    cyc();
                end
                in_valid = 1'b1; in_op = op; in_sew = sew; in_vec0 = v0; in_vec1 = v1;
                in_be = ($urandom_range(2) == 0) ? 8'($urandom) : 8'hFF;
                in_addr = $urandom; in_first = (b == 0); in_last = (b == len - 1);
                k = 0;
                do begin
                    out_ready = ($urandom_range(3) != 0);
                    sat_clr = ($urandom_range(9) == 0);
                    cyc();
                    k++;
                end while (!acc && k < 100);
                chk("rand_accepted", 64'(acc), 64'd1);
            end
        end
        in_valid = 1'b0; sat_clr = 1'b0; out_ready = 1'b1;
        repeat (10) cyc();
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
